// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 lane selector: log2(N) registered 2:1 levels carrying valid and sel alongside the data.
// Global stall (en), synchronous valid flush (clear), asynchronous reset.
module mux_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic [N*WIDTH-1:0]     data,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic [$clog2(N)-1:0]   sel_out
);
  localparam int L = $clog2(N);

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : lvl
      localparam int M = N >> (gi + 1);

      logic [2*M-1:0][WIDTH-1:0] prev_lanes;
      logic [L-1:0]              prev_sel;
      logic                      prev_valid;
      logic [M-1:0][WIDTH-1:0]   lane_reg;
      logic [M-1:0][WIDTH-1:0]   lane_next;
      logic [L-1:0]              sel_reg;
      logic                      valid_reg;

      // Level 0 reads the raw inputs; every later level reads the level before it.
      if (gi == 0) begin : g_src
        assign prev_lanes = data;
        assign prev_sel   = sel;
        assign prev_valid = in_valid;
      end else begin : g_src
        assign prev_lanes = lvl[gi-1].lane_reg;
        assign prev_sel   = lvl[gi-1].sel_reg;
        assign prev_valid = lvl[gi-1].valid_reg;
      end

      always_comb begin
        lane_next = '0;
        for (int j = 0; j < M; j++) begin
          lane_next[j] = prev_sel[gi] ? prev_lanes[2*j+1] : prev_lanes[2*j];
        end
      end

      // The full sel travels with the data so later levels and sel_out see the matching index.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_reg  <= '0;
          sel_reg   <= '0;
          valid_reg <= 1'b0;
        end else begin
          if (en) begin
            lane_reg <= lane_next;
            sel_reg  <= prev_sel;
          end
          if (clear) begin
            valid_reg <= 1'b0;
          end else if (en) begin
            valid_reg <= prev_valid;
          end
        end
      end
    end
  endgenerate

  assign out       = lvl[L-1].lane_reg[0];
  assign out_valid = lvl[L-1].valid_reg;
  assign sel_out   = lvl[L-1].sel_reg;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed and random checks of mux_tree_pipe at N=16/W=8, N=2/W=1 and N=64/W=32.
// Expected lanes are queued at sampling edges and compared when out_valid is loaded.
module tb_mux_tree_pipe;
  typedef struct {
    logic [31:0] val;
    logic [5:0]  sel;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         en, clear, in_valid;
  logic [3:0]   sel;
  logic [127:0] data;
  logic [7:0]   out;
  logic         out_valid;
  logic [3:0]   sel_out;

  logic         en2, in_valid2;
  logic [0:0]   sel2;
  logic [1:0]   data2;
  logic [0:0]   out2;
  logic         out_valid2;
  logic [0:0]   sel_out2;

  logic          en64, in_valid64;
  logic [5:0]    sel64;
  logic [2047:0] data64;
  logic [31:0]   out64;
  logic          out_valid64;
  logic [5:0]    sel_out64;

  mux_tree_pipe #(.WIDTH(8), .N(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .in_valid(in_valid),
    .sel(sel), .data(data), .out(out), .out_valid(out_valid), .sel_out(sel_out));

  mux_tree_pipe #(.WIDTH(1), .N(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .clear(1'b0), .in_valid(in_valid2),
    .sel(sel2), .data(data2), .out(out2), .out_valid(out_valid2), .sel_out(sel_out2));

  mux_tree_pipe #(.WIDTH(32), .N(64)) dut64 (
    .clk(clk), .reset(reset), .en(en64), .clear(1'b0), .in_valid(in_valid64),
    .sel(sel64), .data(data64), .out(out64), .out_valid(out_valid64), .sel_out(sel_out64));

  exp_t q16[$];
  exp_t q2[$];
  exp_t q64[$];
  int vectors = 0;
  int errors  = 0;
  int edges16 = 0, edges2 = 0, edges64 = 0;
  int pops16  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: queue what each DUT samples, then compare whatever each DUT newly presents.
  task automatic tick();
    exp_t e;
    logic s16, s2, s64;
    s16 = en && !reset;
    s2  = en2 && !reset;
    s64 = en64 && !reset;
    if (s16 && in_valid && !clear) q16.push_back('{val: 32'(data[sel*8 +: 8]), sel: 6'(sel), stamp: edges16 + 1});
    if (s2 && in_valid2) q2.push_back('{val: 32'(data2[sel2]), sel: 6'(sel2), stamp: edges2 + 1});
    if (s64 && in_valid64) q64.push_back('{val: data64[sel64*32 +: 32], sel: sel64, stamp: edges64 + 1});
    @(posedge clk);
    #1;
    if (s16) edges16++;
    if (s2)  edges2++;
    if (s64) edges64++;
    if (s16 && out_valid) begin
      chk("dut16_pending", 64'(q16.size() > 0), 64'd1);
      if (q16.size() > 0) begin
        e = q16.pop_front();
        pops16++;
        chk("dut16_out", 64'(out), 64'(e.val));
        chk("dut16_sel_out", 64'(sel_out), 64'(e.sel));
        chk("dut16_latency", 64'(edges16 - e.stamp), 64'd3);
      end
    end
    if (s2 && out_valid2) begin
      chk("dut2_pending", 64'(q2.size() > 0), 64'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("dut2_out", 64'(out2), 64'(e.val));
        chk("dut2_sel_out", 64'(sel_out2), 64'(e.sel));
        chk("dut2_latency", 64'(edges2 - e.stamp), 64'd0);
      end
    end
    if (s64 && out_valid64) begin
      chk("dut64_pending", 64'(q64.size() > 0), 64'd1);
      if (q64.size() > 0) begin
        e = q64.pop_front();
        chk("dut64_out", 64'(out64), 64'(e.val));
        chk("dut64_sel_out", 64'(sel_out64), 64'(e.sel));
        chk("dut64_latency", 64'(edges64 - e.stamp), 64'd5);
      end
    end
  endtask

  initial begin
    logic [7:0] snap_out;
    logic       snap_valid;
    logic [3:0] snap_sel;
    int         nvalid;
    int         p0;

    reset = 1'b0;
    en = 1'b0; clear = 1'b0; in_valid = 1'b0; sel = '0;
    for (int i = 0; i < 16; i++) data[i*8 +: 8] = 8'h10 + 8'(i);
    en2 = 1'b0; in_valid2 = 1'b0; sel2 = '0; data2 = '0;
    en64 = 1'b0; in_valid64 = 1'b0; sel64 = '0; data64 = '0;

    #1 reset = 1'b1;
    #1;
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_sel_out", 64'(sel_out), 64'd0);
    chk("reset_valid2", 64'(out_valid2), 64'd0);
    chk("reset_valid64", 64'(out_valid64), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    en = 1'b1;

    // Single sample: valid exactly once, four cycles after the drive.
    sel = 4'd5; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      chk("lat_valid", 64'(out_valid), 64'(i == 4));
      if (i < 4) chk("lat_pre_out", 64'(out), 64'd0);
    end
    chk("lat_out", 64'(out), 64'h15);

    // Every select value back to back.
    nvalid = 0;
    p0 = pops16;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s); in_valid = 1'b1;
      tick();
      if (out_valid) nvalid++;
    end
    in_valid = 1'b0;
    repeat (4) begin
      tick();
      if (out_valid) nvalid++;
    end
    chk("exh_count", 64'(nvalid), 64'd16);
    chk("exh_pops", 64'(pops16 - p0), 64'd16);
    chk("exh_drained", 64'(q16.size()), 64'd0);

    // Stall between the second and third sample.
    p0 = pops16;
    sel = 4'd3; in_valid = 1'b1; tick();
    sel = 4'd7; tick();
    in_valid = 1'b0; en = 1'b0;
    snap_out = out; snap_valid = out_valid; snap_sel = sel_out;
    repeat (5) begin
      tick();
      chk("stall_out", 64'(out), 64'(snap_out));
      chk("stall_valid", 64'(out_valid), 64'(snap_valid));
      chk("stall_sel_out", 64'(sel_out), 64'(snap_sel));
    end
    en = 1'b1;
    sel = 4'd11; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("stall_pops", 64'(pops16 - p0), 64'd3);
    chk("stall_drained", 64'(q16.size()), 64'd0);

    // Flush with en=1 drops everything in flight.
    for (int s = 0; s < 4; s++) begin
      sel = 4'(s); in_valid = 1'b1; tick();
    end
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    q16.delete();
    chk("flush_valid0", 64'(out_valid), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("flush_valid", 64'(out_valid), 64'd0);
    end
    sel = 4'd9; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      chk("flush_resume", 64'(out_valid), 64'(i == 4));
    end
    // Flush while stalled: valid drops, data holds.
    en = 1'b0; clear = 1'b1;
    tick();
    chk("clr_stall_valid", 64'(out_valid), 64'd0);
    chk("clr_stall_out", 64'(out), 64'h19);
    clear = 1'b0; en = 1'b1;

    // Asynchronous reset between edges while output is valid.
    sel = 4'd2; in_valid = 1'b1;
    repeat (5) tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out", 64'(out), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_sel_out", 64'(sel_out), 64'd0);
    q16.delete();
    in_valid = 1'b0;
    repeat (2) begin
      tick();
      chk("arst_hold_valid", 64'(out_valid), 64'd0);
      chk("arst_hold_out", 64'(out), 64'd0);
    end
    #3 reset = 1'b0;
    sel = 4'd6; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      chk("rst_resume", 64'(out_valid), 64'(i == 4));
      if (i < 4) chk("rst_resume_out", 64'(out), 64'd0);
    end
    chk("rst_resume_val", 64'(out), 64'h16);

    // Random sweep of the N=2 and N=64 configurations.
    for (int c = 0; c < 10000; c++) begin
      en2 = ($urandom_range(0, 3) != 0);
      in_valid2 = 1'($urandom);
      sel2 = 1'($urandom);
      data2 = 2'($urandom);
      en64 = ($urandom_range(0, 3) != 0);
      in_valid64 = 1'($urandom);
      sel64 = 6'($urandom);
      for (int w = 0; w < 64; w++) data64[w*32 +: 32] = $urandom;
      tick();
    end
    en2 = 1'b1; in_valid2 = 1'b0;
    en64 = 1'b1; in_valid64 = 1'b0;
    repeat (8) tick();
    chk("sweep2_drained", 64'(q2.size()), 64'd0);
    chk("sweep64_drained", 64'(q64.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
